// File: rtl/sm_intc.sv
// ----------------------------------------------------------------------------
// sm_intc - interrupt controller feeding the CP0 hardware interrupt input.
//
// Each of the N_IRQ asynchronous peripheral lines is synchronized through two
// flops plus a history flop. A line is latched into PEND either as a level
// (PEND follows the synchronized line) or as a rising edge (sticky until
// software clears it). PEND is masked by MASK and the OR of the enabled
// pending bits is registered onto cp0_ExcIP2.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   irq_src     raw peripheral interrupt lines, active-high, asynchronous
//   bSel        slave select
//   bWE         write strobe (qualified by bSel)
//   bRE         read strobe (qualified by bSel); a CLAIM read clears the
//               claimed edge-mode bit
//   bAddr       word address: 0 PEND, 1 MASK, 2 MODE, 3 CLAIM
//   bWD         write data
//   bRD         read data, combinational from current register state
//   cp0_ExcIP2  registered interrupt request to CP0
// ----------------------------------------------------------------------------
module sm_intc #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             bSel,
    input  logic             bWE,
    input  logic             bRE,
    input  logic [1:0]       bAddr,
    input  logic [31:0]      bWD,
    output logic [31:0]      bRD,
    output logic             cp0_ExcIP2
);

    localparam int PAD = 32 - N_IRQ;

    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;
    logic [N_IRQ-1:0] hist_r;
    logic [N_IRQ-1:0] pend_r;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] mode_r;
    logic             irq_r;

    logic             wr_pend_s;
    logic             wr_mask_s;
    logic             wr_mode_s;
    logic             rd_claim_s;
    logic [N_IRQ-1:0] pm_s;
    logic [N_IRQ-1:0] edge_s;
    logic [N_IRQ-1:0] w1c_s;
    logic [N_IRQ-1:0] mode_chg_s;
    logic [N_IRQ-1:0] claim_clr_s;
    logic [N_IRQ-1:0] pend_next_s;
    logic             claim_valid_s;
    logic [4:0]       claim_id_s;
    logic [31:0]      rd_data_s;

    // Slave port access decode.
    always_comb begin
        wr_pend_s  = bSel & bWE & (bAddr == 2'd0);
        wr_mask_s  = bSel & bWE & (bAddr == 2'd1);
        wr_mode_s  = bSel & bWE & (bAddr == 2'd2);
        rd_claim_s = bSel & bRE & (bAddr == 2'd3);
    end

    // Per-bit event terms feeding the PEND update.
    always_comb begin
        pm_s   = pend_r & mask_r;
        edge_s = sync2_r & ~hist_r;
        if (wr_pend_s) begin
            w1c_s = bWD[N_IRQ-1:0];
        end else begin
            w1c_s = '0;
        end
        // Only bits whose mode actually flips lose their pending state.
        if (wr_mode_s) begin
            mode_chg_s = bWD[N_IRQ-1:0] ^ mode_r;
        end else begin
            mode_chg_s = '0;
        end
    end

    // Priority encoder: lowest enabled pending index wins. Scanning from the
    // top down lets the lowest index overwrite any higher one.
    always_comb begin
        claim_valid_s = 1'b0;
        claim_id_s    = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            claim_valid_s = pm_s[i] ? 1'b1  : claim_valid_s;
            claim_id_s    = pm_s[i] ? 5'(i) : claim_id_s;
        end
    end

    // One-hot clear for the bit returned by a valid CLAIM read.
    always_comb begin
        claim_clr_s = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            claim_clr_s[i] = rd_claim_s & claim_valid_s & (claim_id_s == 5'(i));
        end
    end

    // Next PEND value. Precedence on one bit: mode change clear, then a new
    // edge (so a simultaneous W1C or claim never loses a fresh event), then
    // software clears. Level bits simply track the synchronized line.
    always_comb begin
        pend_next_s = pend_r;
        for (int i = 0; i < N_IRQ; i++) begin
            if (mode_chg_s[i]) begin
                pend_next_s[i] = 1'b0;
            end else if (mode_r[i]) begin
                if (edge_s[i]) begin
                    pend_next_s[i] = 1'b1;
                end else if (w1c_s[i] | claim_clr_s[i]) begin
                    pend_next_s[i] = 1'b0;
                end else begin
                    pend_next_s[i] = pend_r[i];
                end
            end else begin
                pend_next_s[i] = sync2_r[i];
            end
        end
    end

    // Read mux; CLAIM shows the pre-clear value because it is built from
    // the current PEND.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (bSel) begin
            case (bAddr)
                2'd0:    rd_data_s = {{PAD{1'b0}}, pend_r};
                2'd1:    rd_data_s = {{PAD{1'b0}}, mask_r};
                2'd2:    rd_data_s = {{PAD{1'b0}}, mode_r};
                2'd3: begin
                    if (claim_valid_s) begin
                        rd_data_s = {1'b1, 26'd0, claim_id_s};
                    end else begin
                        rd_data_s = 32'h0000_0000;
                    end
                end
                default: rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    assign bRD        = rd_data_s;
    assign cp0_ExcIP2 = irq_r;

    // Input synchronizer and edge history; history runs regardless of mode
    // so a mode switch never fabricates an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            hist_r  <= '0;
        end else begin
            sync1_r <= irq_src;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            mask_r <= '0;
            mode_r <= '0;
        end else begin
            pend_r <= pend_next_s;
            if (wr_mask_s) begin
                mask_r <= bWD[N_IRQ-1:0];
            end
            if (wr_mode_s) begin
                mode_r <= bWD[N_IRQ-1:0];
            end
        end
    end

    // Registered interrupt request; a MASK write shows up here one cycle
    // after the MASK register itself changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |pm_s;
        end
    end

endmodule
